// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - central hazard controller for the 5-stage MIPS pipeline
module hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_ex_mem_read,
  input  logic [4:0]       id_ex_rt,
  input  logic             ex_mispredict,
  input  logic             icache_ready,
  input  logic             dcache_busy,
  output logic             pc_write_en,
  output logic             pc_redirect,
  output logic             if_id_write_en,
  output logic             if_id_flush_en,
  output logic             id_ex_write_en,
  output logic             id_ex_flush_en,
  output logic             ex_mem_write_en,
  output logic             mem_wb_flush_en,
  output logic             icache_discard,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic {RUN, DSTALL} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t state, state_nxt;
  logic   drop_pending, drop_nxt;
  logic   lu;
  logic   flush_inc;

  always_comb begin
    lu = id_ex_mem_read && (id_ex_rt != 5'd0) &&
         ((id_ex_rt == id_rs) || (id_uses_rt && (id_ex_rt == id_rt)));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (dcache_busy)  state_nxt = DSTALL;
      DSTALL:  if (!dcache_busy) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    pc_write_en     = 1'b1;
    pc_redirect     = 1'b0;
    if_id_write_en  = 1'b1;
    if_id_flush_en  = 1'b0;
    id_ex_write_en  = 1'b1;
    id_ex_flush_en  = 1'b0;
    ex_mem_write_en = 1'b1;
    mem_wb_flush_en = 1'b0;
    icache_discard  = 1'b0;
    drop_nxt        = drop_pending;
    flush_inc       = 1'b0;

    // The D-cache freeze holds EX, so a mispredict there re-presents after the miss
    if (dcache_busy) begin
      pc_write_en     = 1'b0;
      if_id_write_en  = 1'b0;
      id_ex_write_en  = 1'b0;
      ex_mem_write_en = 1'b0;
      mem_wb_flush_en = 1'b1;
    end else if (ex_mispredict) begin
      pc_redirect    = 1'b1;
      if_id_flush_en = 1'b1;
      id_ex_flush_en = 1'b1;
      flush_inc      = 1'b1;
      if (!icache_ready) drop_nxt = 1'b1;
    end else if (drop_pending && icache_ready) begin
      // The PC already holds the redirect target; only the stale word is dropped
      icache_discard = 1'b1;
      if_id_flush_en = 1'b1;
      pc_write_en    = 1'b0;
      drop_nxt       = 1'b0;
    end else if (lu) begin
      pc_write_en    = 1'b0;
      if_id_write_en = 1'b0;
      id_ex_flush_en = 1'b1;
    end else if (!icache_ready || drop_pending) begin
      pc_write_en    = 1'b0;
      if_id_flush_en = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RUN;
      drop_pending <= 1'b0;
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      state        <= state_nxt;
      drop_pending <= drop_nxt;
      if (!pc_write_en && (stall_cycles != {CNT_W{1'b1}}))
        stall_cycles <= stall_cycles + CNT_ONE;
      if (flush_inc && (flush_count != {CNT_W{1'b1}}))
        flush_count <= flush_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - vector table and scoreboard bench for hazard_ctrl
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] id_rs, id_rt, id_ex_rt;
  logic id_uses_rt, id_ex_mem_read, ex_mispredict, icache_ready, dcache_busy;
  logic pc_write_en, pc_redirect, if_id_write_en, if_id_flush_en;
  logic id_ex_write_en, id_ex_flush_en, ex_mem_write_en, mem_wb_flush_en, icache_discard;
  logic [15:0] stall_cycles, flush_count;
  logic s_pc_we, s_redir, s_ifw, s_iff, s_idw, s_idf, s_exw, s_mwf, s_disc;
  logic [3:0] s_stall, s_flush;

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt), .ex_mispredict(ex_mispredict),
    .icache_ready(icache_ready), .dcache_busy(dcache_busy),
    .pc_write_en(pc_write_en), .pc_redirect(pc_redirect), .if_id_write_en(if_id_write_en),
    .if_id_flush_en(if_id_flush_en), .id_ex_write_en(id_ex_write_en),
    .id_ex_flush_en(id_ex_flush_en), .ex_mem_write_en(ex_mem_write_en),
    .mem_wb_flush_en(mem_wb_flush_en), .icache_discard(icache_discard),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  hazard_ctrl #(.CNT_W(4)) sat (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt), .ex_mispredict(ex_mispredict),
    .icache_ready(icache_ready), .dcache_busy(dcache_busy),
    .pc_write_en(s_pc_we), .pc_redirect(s_redir), .if_id_write_en(s_ifw),
    .if_id_flush_en(s_iff), .id_ex_write_en(s_idw), .id_ex_flush_en(s_idf),
    .ex_mem_write_en(s_exw), .mem_wb_flush_en(s_mwf), .icache_discard(s_disc),
    .stall_cycles(s_stall), .flush_count(s_flush)
  );

  // {pc_we, redirect, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, memwb_flush, discard}
  logic [8:0] ctrl;
  assign ctrl = {pc_write_en, pc_redirect, if_id_write_en, if_id_flush_en, id_ex_write_en,
                 id_ex_flush_en, ex_mem_write_en, mem_wb_flush_en, icache_discard};

  localparam logic [8:0] DEF  = 9'b101010100;
  localparam logic [8:0] DC   = 9'b000000010;
  localparam logic [8:0] MP   = 9'b111111100;
  localparam logic [8:0] DROP = 9'b001110101;
  localparam logic [8:0] LU   = 9'b000011100;
  localparam logic [8:0] IM   = 9'b001110100;

  typedef struct {
    logic       mr;
    logic [4:0] ex_rt, rs, rt;
    logic       uses, mp, rdy, dc;
    logic [8:0] exp;
  } vec_t;

  vec_t tbl[13];
  logic [8:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int exp_stall, exp_flush;

  function automatic vec_t mk(logic mr, logic [4:0] ex_rt, logic [4:0] rs, logic [4:0] rt,
                              logic uses, logic mp, logic rdy, logic dc, logic [8:0] e);
    vec_t v;
    v.mr = mr; v.ex_rt = ex_rt; v.rs = rs; v.rt = rt; v.uses = uses;
    v.mp = mp; v.rdy = rdy; v.dc = dc; v.exp = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    id_ex_mem_read = v.mr; id_ex_rt = v.ex_rt; id_rs = v.rs; id_rt = v.rt;
    id_uses_rt = v.uses; ex_mispredict = v.mp; icache_ready = v.rdy; dcache_busy = v.dc;
  endtask

  task automatic apply(input string name, input vec_t v);
    logic [8:0] e;
    @(posedge clk);
    #1;
    drive(v);
    exp_q.push_back(v.exp);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s scoreboard empty", name);
    end else begin
      e = exp_q.pop_front();
      check(name, {7'd0, ctrl}, {7'd0, e});
    end
  endtask

  task automatic do_reset();
    drive(mk(0, 0, 0, 0, 0, 0, 1, 0, DEF));
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 1, 0, DEF);
    tbl[1]  = mk(1, 5, 5, 0, 0, 0, 1, 0, LU);
    tbl[2]  = mk(1, 0, 0, 0, 1, 0, 1, 0, DEF);
    tbl[3]  = mk(1, 7, 3, 7, 1, 0, 1, 0, LU);
    tbl[4]  = mk(1, 7, 3, 7, 0, 0, 1, 0, DEF);
    tbl[5]  = mk(0, 5, 5, 5, 1, 0, 1, 0, DEF);
    tbl[6]  = mk(0, 0, 0, 0, 0, 1, 1, 0, MP);
    tbl[7]  = mk(1, 9, 9, 0, 0, 1, 1, 0, MP);
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, IM);
    tbl[9]  = mk(1, 4, 4, 0, 0, 0, 0, 0, LU);
    tbl[10] = mk(0, 0, 0, 0, 0, 1, 1, 1, DC);
    tbl[11] = mk(1, 4, 4, 0, 0, 0, 0, 1, DC);
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 1, 0, DEF);

    do_reset();
    @(negedge clk);
    check("reset_ctrl", {7'd0, ctrl}, {7'd0, DEF});
    check("reset_stall", stall_cycles, 16'd0);
    check("reset_flush", flush_count, 16'd0);

    exp_stall = 0; exp_flush = 0;
    for (int i = 0; i < 13; i++) begin
      apply($sformatf("vec%0d", i), tbl[i]);
      if (i < 12) begin
        if (!tbl[i].exp[8]) exp_stall++;
        if (tbl[i].exp[7])  exp_flush++;
      end
    end
    check("tbl_stall", stall_cycles, 16'(exp_stall));
    check("tbl_flush", flush_count, 16'(exp_flush));

    do_reset();
    apply("lu_stall", mk(1, 5, 5, 0, 0, 0, 1, 0, LU));
    apply("lu_after", mk(1, 0, 0, 0, 0, 0, 1, 0, DEF));
    check("lu_stall_cnt", stall_cycles, 16'd1);

    do_reset();
    apply("mp_rdy", mk(0, 0, 0, 0, 0, 1, 1, 0, MP));
    apply("mp_rdy_next", mk(0, 0, 0, 0, 0, 0, 1, 0, DEF));
    check("mp_rdy_flush", flush_count, 16'd1);

    do_reset();
    apply("mpm_c1", mk(0, 0, 0, 0, 0, 1, 0, 0, MP));
    apply("mpm_c2", mk(0, 0, 0, 0, 0, 0, 0, 0, IM));
    apply("mpm_c3", mk(0, 0, 0, 0, 0, 0, 0, 0, IM));
    apply("mpm_ready", mk(0, 0, 0, 0, 0, 0, 1, 0, DROP));
    apply("mpm_after", mk(0, 0, 0, 0, 0, 0, 1, 0, DEF));
    check("mpm_stall", stall_cycles, 16'd3);
    check("mpm_flush", flush_count, 16'd1);

    do_reset();
    apply("dfz_set", mk(0, 0, 0, 0, 0, 1, 0, 0, MP));
    for (int i = 0; i < 4; i++)
      apply($sformatf("dfz_busy%0d", i), mk(0, 0, 0, 0, 0, 0, 1, 1, DC));
    apply("dfz_discard", mk(0, 0, 0, 0, 0, 0, 1, 0, DROP));
    apply("dfz_after", mk(0, 0, 0, 0, 0, 0, 1, 0, DEF));
    check("dfz_stall", stall_cycles, 16'd5);

    do_reset();
    for (int i = 0; i < 20; i++)
      apply($sformatf("sat%0d", i), mk(0, 0, 0, 0, 0, 0, 0, 0, IM));
    apply("sat_end", mk(0, 0, 0, 0, 0, 0, 1, 0, DEF));
    check("sat_wide", stall_cycles, 16'd20);
    check("sat_narrow", {12'd0, s_stall}, 16'd15);

    do_reset();
    apply("rst_mp", mk(0, 0, 0, 0, 0, 1, 1, 0, MP));
    for (int i = 0; i < 3; i++)
      apply($sformatf("rst_busy%0d", i), mk(0, 0, 0, 0, 0, 0, 1, 1, DC));
    check("rst_pre_stall", stall_cycles, 16'd2);
    rst_n = 1'b0;
    #1;
    check("rst_async_stall", stall_cycles, 16'd0);
    check("rst_async_flush", flush_count, 16'd0);
    check("rst_busy_ctrl", {7'd0, ctrl}, {7'd0, DC});
    dcache_busy = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    apply("rst_release", mk(0, 0, 0, 0, 0, 0, 1, 0, DEF));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
